color_input_encoder: RTL and testbench

Player-input front end for the colour-sequence game. Synchronises and debounces the four raw colour push-buttons, encodes a single accepted press into the 3-bit colour code consumed by the game FSM's `color` input, and flags invalid multi-button presses. An optional response-window timer reports when the player fails to press within `TIME_IN` ticks of being armed.

---
 rtl/color_pkg.sv | 34 +++
 rtl/tick_gen.sv | 29 ++
 rtl/color_input_encoder.sv | 214 +++++++++++++++++++++
 tb/tb_color_input_encoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared definitions for the colour-sequence input path: colour codes,
// input FSM state encoding and the button-to-colour encoder.
package color_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned BTN_W  = 4;

    // Colour codes as seen on the game FSM's colour input
    localparam logic [CODE_W-1:0] RED    = 3'd0;
    localparam logic [CODE_W-1:0] GREEN  = 3'd1;
    localparam logic [CODE_W-1:0] BLUE   = 3'd2;
    localparam logic [CODE_W-1:0] YELLOW = 3'd3;
    localparam logic [CODE_W-1:0] NULL   = 3'd4;

    // Input FSM states
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    // Map a one-hot button vector to its colour; anything else maps to NULL
    function automatic logic [CODE_W-1:0] onehot_to_code(input logic [BTN_W-1:0] oh);
        logic [CODE_W-1:0] code;
        case (oh)
            4'b0001: code = RED;
            4'b0010: code = GREEN;
            4'b0100: code = BLUE;
            4'b1000: code = YELLOW;
            default: code = NULL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running sampling tick: one-clk pulse every COUNT_MAX clocks.
// The counter wraps silently; tick is a decode of the counter register.
module tick_gen #(
    parameter int unsigned COUNT_MAX = 800000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_LAST);

    // Count 0..COUNT_MAX-1, wrapping on the tick cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/color_input_encoder.sv
// Player-input front end: synchronises and debounces the four colour
// buttons, encodes a single accepted press into a colour code and flags
// multi-button presses. Optional response-window timer is built only when
// COLOR_IN_TIMEOUT_EN is defined; otherwise arm is ignored and timeout is 0.
module color_input_encoder
    import color_pkg::*;
#(
    parameter int unsigned COUNT_MAX = 800000,
    parameter int unsigned DEB_TICKS = 3,
    parameter int unsigned TIME_IN   = 50,
    parameter int unsigned IN_BITS   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         btn,
    input  logic               arm,
    output logic [IN_BITS:0]   color,
    output logic               color_valid,
    output logic               multi_err,
    output logic               timeout
);

    localparam int unsigned CW    = IN_BITS + 1;
    localparam int unsigned DEB_W = $clog2(DEB_TICKS + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS);
    localparam logic [CW-1:0]    C_NULL   = CW'(NULL);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic             w_tick;
    logic [3:0]       w_sbtn;

    logic [1:0]       r_state;
    logic [3:0]       r_cand;
    logic [DEB_W-1:0] r_deb;

    logic [1:0]       w_state_nxt;
    logic [3:0]       w_cand_nxt;
    logic [DEB_W-1:0] w_deb_nxt;
    logic [CW-1:0]    w_color_nxt;
    logic             w_cv_nxt;
    logic             w_me_nxt;
    logic             w_enter;
    logic [3:0]       w_enter_cand;
    logic             w_accept;

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sbtn = r_sync2;

    tick_gen #(
        .COUNT_MAX (COUNT_MAX)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cand      <= '0;
            r_deb       <= '0;
            color       <= C_NULL;
            color_valid <= 1'b0;
            multi_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_deb       <= w_deb_nxt;
            color       <= w_color_nxt;
            color_valid <= w_cv_nxt;
            multi_err   <= w_me_nxt;
        end
    end

    // Next-state logic; everything advances only on a sampling tick
    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_deb_nxt    = r_deb;
        w_color_nxt  = color;
        w_cv_nxt     = 1'b0;
        w_me_nxt     = 1'b0;
        w_enter      = 1'b0;
        w_enter_cand = r_cand;
        w_accept     = 1'b0;

        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    w_color_nxt = C_NULL;
                    if (w_sbtn != 4'd0) begin
                        w_cand_nxt = w_sbtn;
                        w_deb_nxt  = DEB_W'(1);
                        if (DEB_TICKS <= 1) begin
                            w_enter      = 1'b1;
                            w_enter_cand = w_sbtn;
                        end else begin
                            w_state_nxt = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (w_sbtn == 4'd0) begin
                        // glitch rejected, nothing reported
                        w_state_nxt = IDLE;
                        w_deb_nxt   = '0;
                    end else if (w_sbtn != r_cand) begin
                        w_cand_nxt = w_sbtn;
                        w_deb_nxt  = DEB_W'(1);
                    end else if ((r_deb >= DEB_LAST) ||
                                 (r_deb + DEB_W'(1) == DEB_LAST)) begin
                        w_deb_nxt    = DEB_LAST;
                        w_enter      = 1'b1;
                        w_enter_cand = r_cand;
                    end else begin
                        w_deb_nxt = r_deb + DEB_W'(1);
                    end
                end
                PRESSED: begin
                    if (w_sbtn == 4'd0) begin
                        w_deb_nxt = DEB_W'(1);
                        if (DEB_TICKS <= 1) begin
                            w_state_nxt = IDLE;
                            w_color_nxt = C_NULL;
                        end else begin
                            w_state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (w_sbtn != 4'd0) begin
                        // bounce during release: back to held, no new pulse
                        w_state_nxt = PRESSED;
                    end else if ((r_deb >= DEB_LAST) ||
                                 (r_deb + DEB_W'(1) == DEB_LAST)) begin
                        w_deb_nxt   = DEB_LAST;
                        w_state_nxt = IDLE;
                        w_color_nxt = C_NULL;
                    end else begin
                        w_deb_nxt = r_deb + DEB_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_color_nxt = C_NULL;
                end
            endcase

            // PRESSED entry: encode a single button, flag anything else
            if (w_enter) begin
                w_state_nxt = PRESSED;
                w_accept    = 1'b1;
                if ($onehot(w_enter_cand)) begin
                    w_color_nxt = CW'(onehot_to_code(w_enter_cand));
                    w_cv_nxt    = 1'b1;
                end else begin
                    w_color_nxt = C_NULL;
                    w_me_nxt    = 1'b1;
                end
            end
        end
    end

`ifdef COLOR_IN_TIMEOUT_EN
    localparam int unsigned TIN_W = $clog2(TIME_IN + 1);
    localparam logic [TIN_W-1:0] TIN_LAST = TIN_W'(TIME_IN);

    logic [TIN_W-1:0] r_tin;
    logic             r_armed;

    // Response window: arm (re)opens it and wins over an acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tin   <= '0;
            r_armed <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (arm) begin
                r_tin   <= '0;
                r_armed <= 1'b1;
            end else if (w_accept) begin
                r_armed <= 1'b0;
            end else if (w_tick && r_armed) begin
                if (r_tin + TIN_W'(1) >= TIN_LAST) begin
                    r_tin   <= TIN_LAST;
                    r_armed <= 1'b0;
                    timeout <= 1'b1;
                end else begin
                    r_tin <= r_tin + TIN_W'(1);
                end
            end
        end
    end
`else
    logic [1:0] w_unused;

    assign w_unused = {arm, w_accept};
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_color_input_encoder.sv
// Scoreboard bench for color_input_encoder (COUNT_MAX=4, DEB_TICKS=3,
// TIME_IN=5). Expected pulses are queued with the sampling tick at which
// they must appear and are matched by a monitor on the falling edge.
module tb_color_input_encoder;

    localparam int unsigned CM = 4;
    localparam int unsigned DT = 3;
    localparam int unsigned TI = 5;

    localparam int K_CV = 1;
    localparam int K_ME = 2;
    localparam int K_TO = 3;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic       arm;
    logic [2:0] color;
    logic       color_valid;
    logic       multi_err;
    logic       timeout;

    typedef struct {
        int kind;
        int code;
        int due;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec;
    int   n_miss;
    int   cyc;

    color_input_encoder #(
        .COUNT_MAX (CM),
        .DEB_TICKS (DT),
        .TIME_IN   (TI),
        .IN_BITS   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .arm         (arm),
        .color       (color),
        .color_valid (color_valid),
        .multi_err   (multi_err),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks since reset release; tick index = cyc / CM after a sample edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int code, input int due);
        exp_t e;
        e.kind = kind;
        e.code = code;
        e.due  = due;
        sb_q.push_back(e);
    endtask

    task automatic take_pulse(input int kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_unexpected_pulse_kind", kind, 0);
        end else begin
            e = sb_q.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_code", int'(color), e.code);
            chk("sb_tick", cyc / int'(CM), e.due);
        end
    endtask

    // Monitor: match every output pulse against the scoreboard
    always @(negedge clk) begin
        if (reset && (color_valid || multi_err || timeout)) begin
            chk("cv_me_exclusive", int'(color_valid & multi_err), 0);
            if (color_valid) take_pulse(K_CV);
            if (multi_err)   take_pulse(K_ME);
            if (timeout)     take_pulse(K_TO);
        end
    end

    // Advance to just after the next sampling-tick edge (bounded)
    task automatic next_tick();
        for (int i = 0; i < 2 * int'(CM); i++) begin
            @(posedge clk);
            #1;
            if (cyc % int'(CM) == 0) return;
        end
        chk("tick_align", cyc % int'(CM), 0);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) next_tick();
    endtask

    function automatic int cur_tick();
        return cyc / int'(CM);
    endfunction

    task automatic drain(input string tag);
        chk(tag, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        int t;
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b0;
        btn    = 4'd0;
        arm    = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_color", int'(color), 4);
        chk("rst_cv", int'(color_valid), 0);
        chk("rst_me", int'(multi_err), 0);
        chk("rst_to", int'(timeout), 0);
        @(negedge clk);
        reset = 1'b1;

        // Single green press held 10 ticks, then release
        next_tick();
        t   = cur_tick();
        btn = 4'b0010;
        push(K_CV, 1, t + int'(DT));
        wait_ticks(2);
        chk("green_not_yet", int'(color), 4);
        wait_ticks(8);
        chk("green_held", int'(color), 1);
        btn = 4'd0;
        wait_ticks(2);
        chk("green_release_pending", int'(color), 1);
        wait_ticks(1);
        chk("green_released", int'(color), 4);
        drain("green_drain");

        // One-tick red glitch is rejected
        btn = 4'b0001;
        wait_ticks(1);
        btn = 4'd0;
        wait_ticks(4);
        chk("glitch_color", int'(color), 4);
        drain("glitch_drain");

        // Red+blue together: one multi_err, colour stays NULL
        t   = cur_tick();
        btn = 4'b0101;
        push(K_ME, 4, t + int'(DT));
        wait_ticks(6);
        chk("multi_color", int'(color), 4);
        btn = 4'd0;
        wait_ticks(4);
        drain("multi_drain");

        // Arm with no press: timeout after TIME_IN ticks (when built in)
        t   = cur_tick();
        arm = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
`ifdef COLOR_IN_TIMEOUT_EN
        push(K_TO, 4, t + int'(TI));
`endif
        wait_ticks(7);
        chk("timeout_color", int'(color), 4);
        drain("timeout_drain");

        // Arm then yellow press: accepted, window closed, no timeout
        t   = cur_tick();
        arm = 1'b1;
        btn = 4'b1000;
        push(K_CV, 3, t + int'(DT));
        @(posedge clk);
        #1;
        arm = 1'b0;
        wait_ticks(8);
        chk("yellow_held", int'(color), 3);
        btn = 4'd0;
        wait_ticks(4);
        chk("yellow_released", int'(color), 4);
        drain("yellow_drain");

        // Blue with a one-tick release bounce: single valid, colour held
        t   = cur_tick();
        btn = 4'b0100;
        push(K_CV, 2, t + int'(DT));
        wait_ticks(3);
        btn = 4'd0;
        wait_ticks(1);
        btn = 4'b0100;
        wait_ticks(4);
        chk("blue_bounce_held", int'(color), 2);
        btn = 4'd0;
        wait_ticks(4);
        chk("blue_released", int'(color), 4);
        drain("blue_drain");

        // Reset mid-press forces NULL; held button is re-debounced after
        t   = cur_tick();
        btn = 4'b0010;
        push(K_CV, 1, t + int'(DT));
        wait_ticks(4);
        chk("pre_reset_color", int'(color), 1);
        drain("pre_reset_drain");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_color", int'(color), 4);
        chk("midrst_cv", int'(color_valid), 0);
        chk("midrst_me", int'(multi_err), 0);
        chk("midrst_to", int'(timeout), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        push(K_CV, 1, int'(DT));
        wait_ticks(2);
        chk("postrst_not_yet", int'(color), 4);
        wait_ticks(2);
        chk("postrst_held", int'(color), 1);
        btn = 4'd0;
        wait_ticks(4);
        chk("postrst_released", int'(color), 4);
        drain("postrst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
